// File: rtl/sine_capture.sv
// ---------------------------------------------------------------------------
// sine_capture
//
// Triggered two-channel capture buffer for the two-port sine generator.
// Every enabled sample pair {din1, din2} is written into a circular buffer of
// DEPTH = 2**A_WIDTH entries. After arm, the block first collects PRE_TRIG
// samples. It then waits for a rising crossing of trig_level on channel 1 and
// fills the rest of the window. The finished window (DEPTH pairs, trigger
// sample at index PRE_TRIG) is replayed in write order on a valid/ready port.
//
// Optional feature: when the macro SINE_CAPTURE_FORCE_TRIG_EN is defined, an
// extra input force_trig turns any accepted WAIT sample into the trigger
// sample.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                sample strobe; din1/din2 accepted while capturing
//   din1, din2        channel samples (din1 is the trigger source)
//   arm               start-capture pulse, honoured only in IDLE
//   trig_level        unsigned trigger threshold
//   busy              high whenever the FSM is not IDLE
//   triggered         high from the trigger sample until return to IDLE
//   rd_valid/rd_ready readout handshake
//   rd_data1/rd_data2 readout sample pair
//   rd_last           marks the DEPTH-th (final) readout sample
//   force_trig        (SINE_CAPTURE_FORCE_TRIG_EN only) forced trigger
//
// Readout handshake: a pair moves on every clock edge where rd_valid and
// rd_ready are both high. While rd_valid is high and rd_ready is low,
// rd_data1, rd_data2 and rd_last are held unchanged. Once raised, rd_valid is
// only lowered by a transfer.
// ---------------------------------------------------------------------------
module sine_capture #(
    parameter int D_WIDTH  = 8,
    parameter int A_WIDTH  = 6,
    parameter int PRE_TRIG = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din1,
    input  logic [D_WIDTH-1:0] din2,
    input  logic               arm,
    input  logic [D_WIDTH-1:0] trig_level,
    output logic               busy,
    output logic               triggered,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [D_WIDTH-1:0] rd_data1,
    output logic [D_WIDTH-1:0] rd_data2,
    output logic               rd_last
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
    ,
    input  logic               force_trig
`endif
);

    localparam int DEPTH = 2 ** A_WIDTH;

    localparam logic [A_WIDTH-1:0] PRE_OFF    = A_WIDTH'(PRE_TRIG);
    localparam logic [A_WIDTH-1:0] PRE_LAST   = A_WIDTH'(PRE_TRIG - 1);
    localparam logic [A_WIDTH-1:0] POST_INIT  = A_WIDTH'(DEPTH - PRE_TRIG - 1);
    localparam logic [A_WIDTH-1:0] POST_ONE   = A_WIDTH'(1);
    localparam logic [A_WIDTH:0]   FETCH_LAST = (A_WIDTH + 1)'(DEPTH - 1);
    localparam logic [A_WIDTH:0]   FETCH_ALL  = (A_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_READ
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [A_WIDTH-1:0] wptr;
    logic [A_WIDTH-1:0] rptr;
    logic [A_WIDTH-1:0] start;
    logic [A_WIDTH-1:0] pre_cnt;
    logic [A_WIDTH-1:0] post_cnt;
    logic [A_WIDTH:0]   fetch_cnt;
    logic [D_WIDTH-1:0] prev;

    logic [D_WIDTH-1:0] mem1 [DEPTH];
    logic [D_WIDTH-1:0] mem2 [DEPTH];

    logic accept;
    logic level_hit;
    logic force_hit;
    logic trig_hit;
    logic fetch;
    logic xfer;
    logic last_xfer;
    logic enter_read;

`ifdef SINE_CAPTURE_FORCE_TRIG_EN
    assign force_hit = force_trig;
`else
    assign force_hit = 1'b0;
`endif

    // Samples are only taken while a capture is in progress.
    assign accept    = en && ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));
    // Rising crossing: previous accepted sample below the level, current at or above.
    assign level_hit = (prev < trig_level) && (din1 >= trig_level);
    assign trig_hit  = (state == S_WAIT) && accept && (level_hit || force_hit);

    // Prefetch the next pair whenever the output register is empty or being drained.
    assign fetch     = (state == S_READ) && (fetch_cnt != FETCH_ALL) && (!rd_valid || rd_ready);
    assign xfer      = rd_valid && rd_ready;
    assign last_xfer = (state == S_READ) && xfer && rd_last;

    assign enter_read = (state_nxt == S_READ) && (state != S_READ);

    assign busy = (state != S_IDLE);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_PRE;
            end
            S_PRE: begin
                // The trigger is not looked at here, so a crossing on the
                // final pre-trigger sample only completes PRE.
                if (accept && (pre_cnt == PRE_LAST)) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (trig_hit) state_nxt = (POST_INIT == '0) ? S_READ : S_POST;
            end
            S_POST: begin
                if (accept && (post_cnt == POST_ONE)) state_nxt = S_READ;
            end
            S_READ: begin
                if (last_xfer) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- capture / readout datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            start     <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            fetch_cnt <= '0;
            prev      <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data1  <= '0;
            rd_data2  <= '0;
        end else begin
            if ((state == S_IDLE) && arm) begin
                wptr    <= '0;
                pre_cnt <= '0;
            end

            if (accept) begin
                wptr <= wptr + 1'b1;
                prev <= din1;
            end

            if ((state == S_PRE) && accept) begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (trig_hit) begin
                triggered <= 1'b1;
                // Window start is PRE_TRIG entries behind the trigger's address.
                start     <= wptr - PRE_OFF;
                post_cnt  <= POST_INIT;
            end

            if ((state == S_POST) && accept) begin
                post_cnt <= post_cnt - 1'b1;
            end

            if (enter_read) begin
                // When WAIT jumps straight to READ, start is being written on
                // this same edge, so take the address from wptr directly.
                rptr      <= (state == S_WAIT) ? (wptr - PRE_OFF) : start;
                fetch_cnt <= '0;
            end else if (fetch) begin
                rptr      <= rptr + 1'b1;
                fetch_cnt <= fetch_cnt + 1'b1;
            end

            if (fetch) begin
                rd_data1 <= mem1[rptr];
                rd_data2 <= mem2[rptr];
                rd_valid <= 1'b1;
                rd_last  <= (fetch_cnt == FETCH_LAST);
            end else if (xfer) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end

            if (last_xfer) begin
                triggered <= 1'b0;
            end
        end
    end

    // ---------------- sample buffer (not cleared by reset) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            mem1[wptr] <= din1;
            mem2[wptr] <= din2;
        end
    end

endmodule

// File: tb/tb_sine_capture.sv
// ---------------------------------------------------------------------------
// tb_sine_capture
//
// Self-checking bench for sine_capture (D_WIDTH=8, A_WIDTH=6, PRE_TRIG=8).
// Each scenario loads a per-sample stimulus list (stim_q). It pushes the
// 64-entry window it expects (stim[trig_idx-8 .. trig_idx+55]) into exp_q.
// It then drives the capture cycle by cycle and pops and compares every
// readout transfer. Channel 2 always carries din1 ^ 8'h5A, so the two
// channels can be told apart.
// ---------------------------------------------------------------------------
module tb_sine_capture;

    localparam int PRE   = 8;
    localparam int DEPTH = 64;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] din1;
    logic [7:0] din2;
    logic       arm;
    logic [7:0] trig_level;
    logic       busy;
    logic       triggered;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic       rd_last;
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
    logic       force_trig;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  stim_q[$];
    logic [15:0] exp_q[$];

    sine_capture dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din1       (din1),
        .din2       (din2),
        .arm        (arm),
        .trig_level (trig_level),
        .busy       (busy),
        .triggered  (triggered),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_last    (rd_last)
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
        ,
        .force_trig (force_trig)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] stim_at(input int i);
        if (i < stim_q.size()) return stim_q[i];
        return stim_q[stim_q.size() - 1];
    endfunction

    task automatic load_ramp(input logic [7:0] v0, input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'(v0 + i));
    endtask

    task automatic push_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(v);
    endtask

    task automatic build_exp(input int trig_idx);
        logic [7:0] v;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            v = stim_at(trig_idx - PRE + i);
            exp_q.push_back({v, v ^ 8'h5A});
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({busy, triggered, rd_valid, rd_last, rd_data1, rd_data2} !== 20'h0) begin
            errors++;
            $display("FAIL %s: busy=%b trig=%b valid=%b last=%b d1=%h d2=%h, expected all 0",
                     tag, busy, triggered, rd_valid, rd_last, rd_data1, rd_data2);
        end
    endtask

    // ---------------- reset ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; din1 = '0; din2 = '0; arm = 1'b0;
        trig_level = '0; rd_ready = 1'b0;
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
        force_trig = 1'b0;
`endif
        #3;
        check_all_zero("reset_values");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset_idle");
        @(posedge clk); #1;
    endtask

    // ---------------- one full capture + readout ----------------
    // en_per: en high every en_per-th cycle; bp: rd_ready pattern 1,0,0,1;
    // rearm: pulse arm again during POST; rst_after: reset after that many
    // transfers (0 = never); force_idx: sample index driven with force_trig.
    task automatic run_capture(input string name, input logic [7:0] level, input int en_per,
                               input bit bp, input bit rearm, input int rst_after,
                               input int trig_idx, input int force_idx);
        int          cyc;
        int          idx;
        int          xfers;
        bit          trig_seen;
        bit          held;
        bit          done;
        bit          aborted;
        logic [15:0] held_d;
        logic        held_last;
        logic [15:0] got;
        logic [15:0] exp_v;
        cyc = 0; idx = 0; xfers = 0; trig_seen = 0; held = 0; done = 0; aborted = 0;
        held_d = '0; held_last = 1'b0;
        build_exp(trig_idx);
        trig_level = level;
        @(posedge clk); #1;
        arm = 1'b1; en = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
        while (!done && cyc < 4000) begin
            en       = ((cyc % en_per) == 0);
            din1     = stim_at(idx);
            din2     = stim_at(idx) ^ 8'h5A;
            arm      = rearm && (idx == trig_idx + 10);
            rd_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
            force_trig = (idx == force_idx);
`endif
            @(negedge clk);
            if (xfers == 0) begin
                checks++;
                if (triggered !== trig_seen) begin
                    errors++;
                    $display("FAIL %s triggered: got %b expected %b at sample %0d",
                             name, triggered, trig_seen, idx);
                end
            end
            if (!trig_seen) begin
                checks++;
                if (busy !== 1'b1 || rd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s capture_busy: busy=%b rd_valid=%b expected 1/0 at sample %0d",
                             name, busy, rd_valid, idx);
                end
            end
            if (held) begin
                checks++;
                if (rd_valid !== 1'b1 || {rd_data1, rd_data2} !== held_d || rd_last !== held_last) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             name, rd_valid, {rd_data1, rd_data2}, rd_last, held_d, held_last);
                end
            end
            if (rd_valid === 1'b1) begin
                if (rd_ready) begin
                    got = {rd_data1, rd_data2};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_xfer: got %h expected no transfer", name, got);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (got !== exp_v) begin
                            errors++;
                            $display("FAIL %s data[%0d]: got %h expected %h", name, xfers, got, exp_v);
                        end
                    end
                    checks++;
                    if (rd_last !== (xfers == DEPTH - 1)) begin
                        errors++;
                        $display("FAIL %s rd_last[%0d]: got %b expected %b",
                                 name, xfers, rd_last, (xfers == DEPTH - 1));
                    end
                    xfers++;
                    held = 0;
                    if (xfers == DEPTH) done = 1;
                end else begin
                    held      = 1;
                    held_d    = {rd_data1, rd_data2};
                    held_last = rd_last;
                end
            end
            if (en && idx == trig_idx) trig_seen = 1;
            if (en) idx++;
            if (rst_after > 0 && xfers == rst_after) begin
                #2 rst = 1'b1;
                #1;
                check_all_zero({name, "_mid_reset"});
                arm = 1'b0; en = 1'b0; rd_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                exp_q.delete();
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b0; arm = 1'b0;
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
        force_trig = 1'b0;
`endif
        if (!aborted) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL %s timeout: got %0d transfers expected %0d", name, xfers, DEPTH);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || triggered !== 1'b0 || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s end_idle: busy=%b trig=%b valid=%b expected 0/0/0",
                         name, busy, triggered, rd_valid);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s leftover: got %0d unread expected 0", name, exp_q.size());
            end
        end
        rd_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_basic();
        load_ramp(8'd0, 250);
        run_capture("basic", 8'd128, 1, 1'b0, 1'b0, 0, 128, -1);
    endtask

    task automatic test_wrap();
        load_ramp(8'd200, 200);
        run_capture("wrap", 8'd20, 1, 1'b0, 1'b0, 0, 76, -1);
    endtask

    task automatic test_no_false_trigger();
        stim_q.delete();
        push_n(8'd200, 100);
        push_n(8'd100, 1);
        push_n(8'd130, 70);
        run_capture("no_false", 8'd128, 1, 1'b0, 1'b0, 0, 101, -1);
    endtask

    task automatic test_backpressure();
        load_ramp(8'd0, 250);
        run_capture("backpressure", 8'd128, 1, 1'b1, 1'b0, 0, 128, -1);
    endtask

    task automatic test_en_gaps_rearm();
        load_ramp(8'd0, 250);
        run_capture("en_gaps", 8'd128, 3, 1'b0, 1'b1, 0, 128, -1);
    endtask

    task automatic test_pre_boundary();
        stim_q.delete();
        push_n(8'd0, 7);
        push_n(8'd200, 3);
        push_n(8'd50, 1);
        push_n(8'd150, 70);
        run_capture("pre_boundary", 8'd128, 1, 1'b0, 1'b0, 0, 11, -1);
    endtask

    task automatic test_reset_mid_readout();
        load_ramp(8'd0, 250);
        run_capture("mid_reset", 8'd128, 1, 1'b0, 1'b0, 10, 128, -1);
        load_ramp(8'd0, 250);
        run_capture("after_reset", 8'd128, 1, 1'b0, 1'b0, 0, 128, -1);
    endtask

`ifdef SINE_CAPTURE_FORCE_TRIG_EN
    task automatic test_force_trig();
        stim_q.delete();
        push_n(8'd200, 150);
        run_capture("force_trig", 8'd128, 1, 1'b0, 1'b0, 0, 50, 50);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_no_false_trigger();
        test_backpressure();
        test_en_gaps_rearm();
        test_pre_boundary();
        test_reset_mid_readout();
`ifdef SINE_CAPTURE_FORCE_TRIG_EN
        test_force_trig();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
